button_events: RTL and testbench

Per-button gesture decoder that sits directly downstream of the 4-button debouncer in the looper front end. It consumes the four debounced button levels and produces single-cycle event pulses (press, release, short click, long press, auto-repeat) plus a held level for the looper control logic. All four channels are independent and share one millisecond-style tick prescaler.

---
 rtl/button_events_if.sv | 31 +++
 rtl/button_events.sv | 175 +++++++++++++++++
 tb/tb_button_events.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_events_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_events_if
//  Description : Bundle of the four debounced button levels and the gesture
//                event outputs produced by button_events.
//                'release' and 'repeat' are SystemVerilog keywords, so those
//                two event vectors are named release_evt and repeat_evt.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_events_if;
    logic [3:0] button;        // debounced button levels
    logic [3:0] press;         // one-cycle pulse on a rising level
    logic [3:0] release_evt;   // one-cycle pulse on a falling level
    logic [3:0] click;         // release before long_press fired
    logic [3:0] long_press;    // hold reached LONG_TICKS
    logic [3:0] repeat_evt;    // every REPEAT_TICKS after long_press
    logic [3:0] held;          // level from press through release

    // Producer of button levels, consumer of events (looper control side).
    modport master (
        output button,
        input  press, release_evt, click, long_press, repeat_evt, held
    );

    // The gesture decoder itself.
    modport slave (
        input  button,
        output press, release_evt, click, long_press, repeat_evt, held
    );
endinterface
`default_nettype wire

// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
//  Module      : button_events
//  Description : Four independent per-button gesture decoders (press, release,
//                click, long press, auto-repeat, held) sharing one free-running
//                tick prescaler. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_events #(
    parameter int TICK_DIV     = 100000,  // clock cycles per tick, >= 2
    parameter int LONG_TICKS   = 1000,    // ticks held before long_press, >= 1
    parameter int REPEAT_TICKS = 200      // ticks between repeat pulses, >= 1
) (
    input  logic            clock,
    input  logic            reset_n,
    button_events_if.slave  bus
);

    localparam int c_NCH    = 4;
    localparam int c_DIV_W  = $clog2(TICK_DIV);
    localparam int c_HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int c_REP_W  = $clog2(REPEAT_TICKS + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_TICKS);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_TICKS);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_REP_W-1:0]  c_REP_ONE   = c_REP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHORT = 2'd1,
        S_LONG  = 2'd2
    } state_t;

    // Shared prescaler
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                w_tick;

    // Per-channel state
    state_t              r_state    [c_NCH];
    state_t              w_state_nxt[c_NCH];
    logic [c_HOLD_W-1:0] r_hold     [c_NCH];
    logic [c_HOLD_W-1:0] w_hold_nxt [c_NCH];
    logic [c_REP_W-1:0]  r_rep      [c_NCH];
    logic [c_REP_W-1:0]  w_rep_nxt  [c_NCH];
    logic [c_NCH-1:0]    r_btn_q;

    // Registered outputs and their next values
    logic [c_NCH-1:0]    r_press,  w_press_nxt;
    logic [c_NCH-1:0]    r_rel,    w_rel_nxt;
    logic [c_NCH-1:0]    r_click,  w_click_nxt;
    logic [c_NCH-1:0]    r_long,   w_long_nxt;
    logic [c_NCH-1:0]    r_rep_p,  w_rep_p_nxt;
    logic [c_NCH-1:0]    r_held,   w_held_nxt;

    // Tick is one cycle wide at the terminal count; never restarted by buttons.
    assign w_tick = (r_div_cnt == c_DIV_LAST);

    // Free-running prescaler 0..TICK_DIV-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    // Next-state and event decode for every channel; release beats tick.
    always_comb begin
        w_press_nxt = '0;
        w_rel_nxt   = '0;
        w_click_nxt = '0;
        w_long_nxt  = '0;
        w_rep_p_nxt = '0;
        w_held_nxt  = r_held;
        for (int i = 0; i < c_NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hold_nxt[i]  = r_hold[i];
            w_rep_nxt[i]   = r_rep[i];
            case (r_state[i])
                S_IDLE: begin
                    if (bus.button[i] && !r_btn_q[i]) begin
                        w_press_nxt[i] = 1'b1;
                        w_held_nxt[i]  = 1'b1;
                        w_hold_nxt[i]  = '0;
                        w_rep_nxt[i]   = '0;
                        w_state_nxt[i] = S_SHORT;
                    end
                end
                S_SHORT: begin
                    if (!bus.button[i]) begin
                        w_rel_nxt[i]   = 1'b1;
                        w_click_nxt[i] = 1'b1;
                        w_held_nxt[i]  = 1'b0;
                        w_hold_nxt[i]  = '0;
                        w_state_nxt[i] = S_IDLE;
                    end else if (w_tick) begin
                        if ((r_hold[i] + c_HOLD_ONE) == c_HOLD_LAST) begin
                            w_long_nxt[i]  = 1'b1;
                            w_hold_nxt[i]  = '0;
                            w_rep_nxt[i]   = '0;
                            w_state_nxt[i] = S_LONG;
                        end else begin
                            w_hold_nxt[i] = r_hold[i] + c_HOLD_ONE;
                        end
                    end
                end
                S_LONG: begin
                    if (!bus.button[i]) begin
                        w_rel_nxt[i]   = 1'b1;
                        w_held_nxt[i]  = 1'b0;
                        w_rep_nxt[i]   = '0;
                        w_state_nxt[i] = S_IDLE;
                    end else if (w_tick) begin
                        if ((r_rep[i] + c_REP_ONE) == c_REP_LAST) begin
                            w_rep_p_nxt[i] = 1'b1;
                            w_rep_nxt[i]   = '0;
                        end else begin
                            w_rep_nxt[i] = r_rep[i] + c_REP_ONE;
                        end
                    end
                end
                default: begin
                    w_held_nxt[i]  = 1'b0;
                    w_hold_nxt[i]  = '0;
                    w_rep_nxt[i]   = '0;
                    w_state_nxt[i] = S_IDLE;
                end
            endcase
        end
    end

    // State, counters, previous button sample and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_NCH; i++) begin
                r_state[i] <= S_IDLE;
                r_hold[i]  <= '0;
                r_rep[i]   <= '0;
            end
            r_btn_q <= '0;
            r_press <= '0;
            r_rel   <= '0;
            r_click <= '0;
            r_long  <= '0;
            r_rep_p <= '0;
            r_held  <= '0;
        end else begin
            for (int i = 0; i < c_NCH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_hold[i]  <= w_hold_nxt[i];
                r_rep[i]   <= w_rep_nxt[i];
            end
            r_btn_q <= bus.button;
            r_press <= w_press_nxt;
            r_rel   <= w_rel_nxt;
            r_click <= w_click_nxt;
            r_long  <= w_long_nxt;
            r_rep_p <= w_rep_p_nxt;
            r_held  <= w_held_nxt;
        end
    end

    assign bus.press       = r_press;
    assign bus.release_evt = r_rel;
    assign bus.click       = r_click;
    assign bus.long_press  = r_long;
    assign bus.repeat_evt  = r_rep_p;
    assign bus.held        = r_held;

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_events
//  Description : Self-checking bench for button_events. A behavioural model
//                predicts each cycle's outputs into a queue when the button
//                levels are sampled; each scenario task pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_events;

    localparam int TICK_DIV     = 10;
    localparam int LONG_TICKS   = 5;
    localparam int REPEAT_TICKS = 2;

    typedef logic [23:0] vec_t;   // {press, release, click, long, repeat, held}

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;

    button_events_if bus();

    button_events #(
        .TICK_DIV    (TICK_DIV),
        .LONG_TICKS  (LONG_TICKS),
        .REPEAT_TICKS(REPEAT_TICKS)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    vec_t w_obs;
    assign w_obs = {bus.press, bus.release_evt, bus.click,
                    bus.long_press, bus.repeat_evt, bus.held};

    // ---------------- behavioural model / scoreboard ----------------
    vec_t       exp_q[$];
    int         m_div;
    logic [3:0] m_prev, m_held, m_longd;
    int         m_ticks[4];

    task automatic model_clear();
        m_div   = 0;
        m_prev  = '0;
        m_held  = '0;
        m_longd = '0;
        for (int i = 0; i < 4; i++) m_ticks[i] = 0;
        exp_q.delete();
    endtask

    // Counts ticks since the press; long fires on the LONG_TICKS-th tick,
    // repeats on every REPEAT_TICKS-th tick beyond that.
    task automatic model_step();
        vec_t e;
        logic tk;
        e = '0;
        if (!reset_n) begin
            model_clear();
            return;
        end
        tk    = (m_div == TICK_DIV - 1);
        m_div = tk ? 0 : m_div + 1;
        for (int i = 0; i < 4; i++) begin
            if (!m_held[i]) begin
                if (bus.button[i] && !m_prev[i]) begin
                    e[20+i]    = 1'b1;
                    m_held[i]  = 1'b1;
                    m_ticks[i] = 0;
                    m_longd[i] = 1'b0;
                end
            end else if (!bus.button[i]) begin
                e[16+i]   = 1'b1;
                e[12+i]   = !m_longd[i];
                m_held[i] = 1'b0;
            end else if (tk) begin
                m_ticks[i]++;
                if (m_ticks[i] == LONG_TICKS) begin
                    e[8+i]     = 1'b1;
                    m_longd[i] = 1'b1;
                end else if (m_ticks[i] > LONG_TICKS &&
                             ((m_ticks[i] - LONG_TICKS) % REPEAT_TICKS) == 0) begin
                    e[4+i] = 1'b1;
                end
            end
            e[i]      = m_held[i];
            m_prev[i] = bus.button[i];
        end
        exp_q.push_back(e);
    endtask

    function automatic vec_t pop_exp();
        if (exp_q.size() == 0) return '0;
        return exp_q.pop_front();
    endfunction

    // Advance one clock; model samples inputs at the edge, caller checks at negedge.
    task automatic next_cycle();
        @(posedge clock);
        cyc++;
        model_step();
        @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        vec_t e;
        model_clear();
        bus.button = 4'b1000;          // held through reset
        reset_n    = 1'b0;
        repeat (3) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL reset_state got=%h exp=%h", w_obs, e); end
        end
        reset_n = 1'b1;
        next_cycle(); total++;
        if (bus.press !== 4'b1000) begin bad++; $display("FAIL press_after_reset got=%b exp=%b", bus.press, 4'b1000); end
        e = pop_exp(); total++;
        if (w_obs !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", w_obs, e); end
        bus.button = 4'b0000;
        repeat (3) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", w_obs, e); end
        end
    endtask

    task automatic test_short_click();
        vec_t e;
        int held_len = 0;
        int longs    = 0;
        bus.button = 4'b0001;
        for (int c = 0; c < 26; c++) begin
            if (c == 20) bus.button = 4'b0000;
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL short_click cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
            if (bus.held[0]) held_len++;
            if (bus.long_press[0]) longs++;
        end
        total++;
        if (held_len !== 20) begin bad++; $display("FAIL short_held_len got=%0d exp=20", held_len); end
        total++;
        if (longs !== 0) begin bad++; $display("FAIL short_no_long got=%0d exp=0", longs); end
    endtask

    task automatic test_long_repeat();
        vec_t e;
        int p_cyc = -1, l_cyc = -1, last = -1;
        int longs = 0, reps = 0, clicks = 0, rels = 0;
        bus.button = 4'b0010;
        for (int c = 0; c < 126; c++) begin
            if (c == 120) bus.button = 4'b0000;
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL long_repeat cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
            if (bus.press[1]) p_cyc = cyc;
            if (bus.long_press[1]) begin longs++; l_cyc = cyc; last = cyc; end
            if (bus.repeat_evt[1]) begin
                reps++; total++;
                if (cyc - last !== 20) begin bad++; $display("FAIL repeat_period got=%0d exp=20", cyc - last); end
                last = cyc;
            end
            if (bus.click[1]) clicks++;
            if (bus.release_evt[1]) rels++;
        end
        total++;
        if (l_cyc - p_cyc < 41 || l_cyc - p_cyc > 50) begin
            bad++; $display("FAIL long_latency got=%0d exp=41..50", l_cyc - p_cyc);
        end
        total++;
        if (longs !== 1) begin bad++; $display("FAIL long_count got=%0d exp=1", longs); end
        total++;
        if (reps < 3) begin bad++; $display("FAIL repeat_count got=%0d exp>=3", reps); end
        total++;
        if (clicks !== 0 || rels !== 1) begin
            bad++; $display("FAIL long_release got clicks=%0d rels=%0d exp clicks=0 rels=1", clicks, rels);
        end
    endtask

    task automatic test_release_on_tick();
        vec_t e;
        int  longs = 0, clicks = 0;
        bit  found = 0;
        bus.button = 4'b0100;
        for (int c = 0; c < 100 && !found; c++) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL rel_on_tick cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
            if (bus.long_press[2]) longs++;
            if (m_held[2] && m_div == TICK_DIV - 1 && m_ticks[2] == LONG_TICKS - 1) begin
                bus.button = 4'b0000;
                found = 1;
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL rel_on_tick_timeout got=0 exp=1"); end
        bus.button = 4'b0000;
        repeat (4) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL rel_on_tick cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
            if (bus.long_press[2]) longs++;
            if (bus.click[2]) clicks++;
        end
        total++;
        if (longs !== 0 || clicks !== 1) begin
            bad++; $display("FAIL rel_on_tick_events got long=%0d click=%0d exp long=0 click=1", longs, clicks);
        end
    endtask

    task automatic test_all_four();
        vec_t e;
        logic [3:0] long_seen = '0, click_seen = '0;
        for (int c = 0; c < 95; c++) begin
            bus.button = {c < 90, c < 60, c < 30, c < 15};
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL all_four cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
            if (c == 0) begin
                total++;
                if (bus.press !== 4'b1111) begin bad++; $display("FAIL all_press got=%b exp=1111", bus.press); end
            end
            long_seen  = long_seen | bus.long_press;
            click_seen = click_seen | bus.click;
        end
        total++;
        if (long_seen !== 4'b1100 || click_seen !== 4'b0011) begin
            bad++; $display("FAIL all_four_events got long=%b click=%b exp long=1100 click=0011", long_seen, click_seen);
        end
    endtask

    task automatic test_reset_mid_long();
        vec_t e;
        int rel_cyc, p_cyc = -1, l_cyc = -1, rels = 0;
        bus.button = 4'b1000;
        repeat (60) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL mid_long_pre cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
        end
        total++;
        if (bus.held[3] !== 1'b1) begin bad++; $display("FAIL mid_long_held got=%b exp=1", bus.held[3]); end
        #2 reset_n = 1'b0;
        model_clear();
        #1 total++;
        if (w_obs !== 24'h0) begin bad++; $display("FAIL async_reset got=%h exp=000000", w_obs); end
        repeat (2) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e || dut.w_tick !== 1'b0) begin
                bad++; $display("FAIL in_reset got=%h tick=%b exp=%h tick=0", w_obs, dut.w_tick, e);
            end
        end
        reset_n = 1'b1;
        rel_cyc = cyc;
        for (int c = 0; c < 76; c++) begin
            if (c == 70) bus.button = 4'b0000;
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL mid_long_post cyc=%0d got=%h exp=%h", cyc, w_obs, e); end
            if (bus.press[3] && p_cyc < 0) p_cyc = cyc;
            if (bus.long_press[3] && l_cyc < 0) l_cyc = cyc;
            if (bus.release_evt[3]) rels++;
        end
        total++;
        if (p_cyc !== rel_cyc + 1) begin bad++; $display("FAIL restart_press got=%0d exp=%0d", p_cyc, rel_cyc + 1); end
        total++;
        if (l_cyc - p_cyc < 41 || l_cyc - p_cyc > 50) begin
            bad++; $display("FAIL restart_long got=%0d exp=41..50", l_cyc - p_cyc);
        end
        total++;
        if (rels !== 1) begin bad++; $display("FAIL restart_release got=%0d exp=1", rels); end
    endtask

    task automatic test_prescaler();
        vec_t e;
        int last = -1, ticks = 0;
        bus.button = 4'b0000;
        repeat (1000) begin
            next_cycle(); e = pop_exp(); total++;
            if (w_obs !== e) begin bad++; $display("FAIL prescaler_idle got=%h exp=%h", w_obs, e); end
            if (dut.w_tick === 1'b1) begin
                ticks++;
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== TICK_DIV) begin
                        bad++; $display("FAIL tick_period got=%0d exp=%0d", cyc - last, TICK_DIV);
                    end
                end
                last = cyc;
            end
        end
        total++;
        if (ticks !== 1000 / TICK_DIV) begin bad++; $display("FAIL tick_count got=%0d exp=%0d", ticks, 1000 / TICK_DIV); end
    endtask

    initial begin
        bus.button = 4'b0000;
        test_reset();
        test_short_click();
        test_long_repeat();
        test_release_on_tick();
        test_all_four();
        test_reset_mid_long();
        test_prescaler();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
